// File: rtl/scan_pkg.sv
// Shared types and constants for the scan chain controller.
// Holds the FSM state encoding and the minimum legal chain length.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAPT  = 2'd1,
    SHIFT = 2'd2,
    UPD   = 2'd3
  } scan_state_t;

  localparam int MIN_CHAIN_LEN = 2;

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load, right-shifting register with serial input at the MSB.
// Ports: cp clock, cd async clear (low), load/din parallel load, shift/si serial shift, q contents.
module scan_shift_reg #(
  parameter int W = 16
) (
  input  logic         cp,
  input  logic         cd,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  input  logic         si,
  output logic [W-1:0] q
);

  always_ff @(posedge cp or negedge cd) begin
    if (!cd) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {si, q[W-1:1]};
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: runs capture, CHAIN_LEN shifts and update per start request.
// Ports: cp/cd clock and async clear, start/abort requests, wr_data load pattern,
// chain_so/chain_si serial link, chain_ce/se/ue phase enables, busy/done/aborted status,
// rd_valid/rd_data readback. Define SCAN_PARITY_EN to add the rd_parity output.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 cp,
  input  logic                 cd,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] wr_data,
  input  logic                 chain_so,
  output logic                 chain_si,
  output logic                 chain_ce,
  output logic                 chain_se,
  output logic                 chain_ue,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 rd_valid,
`ifdef SCAN_PARITY_EN
  output logic                 rd_parity,
`endif
  output logic [CHAIN_LEN-1:0] rd_data
);

  if (CHAIN_LEN < MIN_CHAIN_LEN) begin : g_bad_len
    $error("scan_chain_ctrl: CHAIN_LEN below minimum");
  end

  scan_state_t          state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] sr;
  logic                 load;
  logic                 shift;
  logic                 last;

  assign load  = (state == IDLE) && start;
  assign shift = (state == SHIFT);
  assign last  = (cnt == CNT_W'(CHAIN_LEN - 1));

  // se is a register cleared by cd, so si drops with it asynchronously
  assign chain_si = chain_se & sr[0];
  assign rd_data  = sr;

  scan_shift_reg #(
    .W(CHAIN_LEN)
  ) u_sr (
    .cp   (cp),
    .cd   (cd),
    .load (load),
    .shift(shift),
    .din  (wr_data),
    .si   (chain_so),
    .q    (sr)
  );

`ifdef SCAN_PARITY_EN
  always_ff @(posedge cp or negedge cd) begin
    if (!cd) begin
      rd_parity <= 1'b0;
    end else if (load) begin
      rd_parity <= 1'b0;
    end else if (state == UPD) begin
      // sr is stable during UPD, so this matches rd_data once rd_valid rises
      rd_parity <= ^sr;
    end
  end
`endif

  always_ff @(posedge cp or negedge cd) begin
    if (!cd) begin
      state    <= IDLE;
      cnt      <= '0;
      chain_ce <= 1'b0;
      chain_se <= 1'b0;
      chain_ue <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      chain_ce <= 1'b0;
      chain_ue <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= CAPT;
            cnt      <= '0;
            rd_valid <= 1'b0;
            chain_ce <= 1'b1;
            busy     <= 1'b1;
          end
        end
        CAPT: begin
          state    <= SHIFT;
          chain_se <= 1'b1;
        end
        SHIFT: begin
          cnt <= cnt + CNT_W'(1);
          if (abort) begin
            state    <= IDLE;
            chain_se <= 1'b0;
            busy     <= 1'b0;
            aborted  <= 1'b1;
          end else if (last) begin
            state    <= UPD;
            chain_se <= 1'b0;
            chain_ue <= 1'b1;
          end
        end
        UPD: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          rd_valid <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with CHAIN_LEN=8 and a loopback chain model.
// The model captures its functional value on ce, shifts on se, and commits on ue.
module tb_scan_chain_ctrl;

  localparam int N = 8;

  logic         cp = 1'b0;
  logic         cd = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] wr_data = '0;
  logic         chain_so;
  logic         chain_si;
  logic         chain_ce;
  logic         chain_se;
  logic         chain_ue;
  logic         busy;
  logic         done;
  logic         aborted;
  logic         rd_valid;
  logic [N-1:0] rd_data;
`ifdef SCAN_PARITY_EN
  logic         rd_parity;
`endif

  int vec = 0;
  int errs = 0;

  logic [N-1:0] cells = 8'h00;
  logic [N-1:0] func = 8'h3C;

  always #5 cp = ~cp;

  always @(posedge cp) begin
    if (chain_ce) cells <= func;
    else if (chain_se) cells <= {chain_si, cells[N-1:1]};
    if (chain_ue) func <= cells;
  end
  assign chain_so = cells[0];

  scan_chain_ctrl #(
    .CHAIN_LEN(N)
  ) dut (
    .cp       (cp),
    .cd       (cd),
    .start    (start),
    .abort    (abort),
    .wr_data  (wr_data),
    .chain_so (chain_so),
    .chain_si (chain_si),
    .chain_ce (chain_ce),
    .chain_se (chain_se),
    .chain_ue (chain_ue),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .rd_valid (rd_valid),
`ifdef SCAN_PARITY_EN
    .rd_parity(rd_parity),
`endif
    .rd_data  (rd_data)
  );

  task automatic test_reset();
    logic [15:0] obs;
    cd = 1'b0;
    repeat (3) @(negedge cp);
    obs = {chain_ce, chain_se, chain_ue, busy, done, aborted,
           rd_valid, chain_si, rd_data};
    vec++;
    if (obs !== 16'h0) begin
      $display("FAIL reset_outs got %h want 0000", obs);
      errs++;
    end
    cd = 1'b1;
    repeat (5) @(negedge cp);
    vec++;
    if ({busy, done, chain_se} !== 3'b000) begin
      $display("FAIL reset_idle got %b want 000", {busy, done, chain_se});
      errs++;
    end
  endtask

  task automatic test_basic();
    logic [7:0] obs, exp;
    logic [7:0] pat;
    pat = 8'hA5;
    start = 1'b1;
    wr_data = pat;
    for (int c = 1; c <= 11; c++) begin
      @(negedge cp);
      if (c == 1) start = 1'b0;
      obs = {chain_ce, chain_se, chain_ue, busy, done, aborted,
             rd_valid, chain_si};
      exp = {c == 1, c >= 2 && c <= 9, c == 10, c >= 1 && c <= 10,
             c == 11, 1'b0, c == 11,
             (c >= 2 && c <= 9) ? pat[(c + 6) % 8] : 1'b0};
      vec++;
      if (obs !== exp) begin
        $display("FAIL basic_c%0d got %b want %b", c, obs, exp);
        errs++;
      end
    end
    vec++;
    if (rd_data !== 8'h3C) begin
      $display("FAIL basic_rd got %h want 3c", rd_data);
      errs++;
    end
    vec++;
    if (func !== 8'hA5) begin
      $display("FAIL basic_chain got %h want a5", func);
      errs++;
    end
`ifdef SCAN_PARITY_EN
    vec++;
    if (rd_parity !== 1'b0) begin
      $display("FAIL basic_par got %b want 0", rd_parity);
      errs++;
    end
`endif
  endtask

  // entered at the done negedge of the previous operation
  task automatic test_back_to_back();
    logic [6:0] obs, exp;
    start = 1'b1;
    wr_data = 8'h0F;
    for (int c = 1; c <= 11; c++) begin
      @(negedge cp);
      if (c == 1) start = 1'b0;
      obs = {chain_ce, chain_se, chain_ue, busy, done, aborted, rd_valid};
      exp = {c == 1, c >= 2 && c <= 9, c == 10, c >= 1 && c <= 10,
             c == 11, 1'b0, c == 11};
      vec++;
      if (obs !== exp) begin
        $display("FAIL b2b_c%0d got %b want %b", c, obs, exp);
        errs++;
      end
    end
    vec++;
    if (rd_data !== 8'hA5) begin
      $display("FAIL b2b_rd got %h want a5", rd_data);
      errs++;
    end
    vec++;
    if (func !== 8'h0F) begin
      $display("FAIL b2b_chain got %h want 0f", func);
      errs++;
    end
  endtask

  task automatic test_abort();
    logic [6:0] obs, exp;
    @(negedge cp);
    start = 1'b1;
    wr_data = 8'h55;
    for (int c = 1; c <= 11; c++) begin
      @(negedge cp);
      if (c == 1) start = 1'b0;
      obs = {chain_ce, chain_se, chain_ue, busy, done, aborted, rd_valid};
      exp = {c == 1, c >= 2 && c <= 5, 1'b0, c >= 1 && c <= 5,
             1'b0, c == 6, 1'b0};
      vec++;
      if (obs !== exp) begin
        $display("FAIL abort_c%0d got %b want %b", c, obs, exp);
        errs++;
      end
      abort = (c == 5);
    end
    vec++;
    if (func !== 8'h0F) begin
      $display("FAIL abort_chain got %h want 0f", func);
      errs++;
    end
    start = 1'b1;
    wr_data = 8'h3C;
    for (int c = 1; c <= 11; c++) begin
      @(negedge cp);
      if (c == 1) start = 1'b0;
      if (c == 11) begin
        vec++;
        if ({done, rd_valid, rd_data} !== {2'b11, 8'h0F}) begin
          $display("FAIL abort_next got %b%b %h want 11 0f",
                   done, rd_valid, rd_data);
          errs++;
        end
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge cp);
    start = 1'b1;
    wr_data = 8'h77;
    for (int c = 1; c <= 6; c++) begin
      @(negedge cp);
      if (c == 1) start = 1'b0;
    end
    vec++;
    if ({chain_se, busy} !== 2'b11) begin
      $display("FAIL arst_pre got %b want 11", {chain_se, busy});
      errs++;
    end
    #2 cd = 1'b0;
    #1;
    vec++;
    if ({chain_se, busy, chain_si} !== 3'b000) begin
      $display("FAIL arst_drop got %b want 000", {chain_se, busy, chain_si});
      errs++;
    end
    @(negedge cp);
    cd = 1'b1;
    @(negedge cp);
    vec++;
    if ({busy, rd_valid, done} !== 3'b000) begin
      $display("FAIL arst_idle got %b want 000", {busy, rd_valid, done});
      errs++;
    end
    start = 1'b1;
    wr_data = 8'h3D;
    for (int c = 1; c <= 11; c++) begin
      @(negedge cp);
      if (c == 1) start = 1'b0;
      if (c == 11) begin
        vec++;
        if ({done, rd_valid, rd_data} !== {2'b11, 8'h3C}) begin
          $display("FAIL arst_next got %b%b %h want 11 3c",
                   done, rd_valid, rd_data);
          errs++;
        end
`ifdef SCAN_PARITY_EN
        vec++;
        if (rd_parity !== 1'b0) begin
          $display("FAIL arst_par got %b want 0", rd_parity);
          errs++;
        end
`endif
      end
    end
  endtask

  task automatic test_ignored();
    logic [6:0] obs, exp;
    @(negedge cp);
    start = 1'b1;
    wr_data = 8'hC3;
    for (int c = 1; c <= 11; c++) begin
      @(negedge cp);
      obs = {chain_ce, chain_se, chain_ue, busy, done, aborted, rd_valid};
      exp = {c == 1, c >= 2 && c <= 9, c == 10, c >= 1 && c <= 10,
             c == 11, 1'b0, c == 11};
      vec++;
      if (obs !== exp) begin
        $display("FAIL ign_c%0d got %b want %b", c, obs, exp);
        errs++;
      end
`ifdef SCAN_PARITY_EN
      if (c == 5) begin
        vec++;
        if (rd_parity !== 1'b0) begin
          $display("FAIL ign_par_busy got %b want 0", rd_parity);
          errs++;
        end
      end
`endif
      start = (c == 3) || (c == 7);
      abort = (c == 1) || (c == 10);
      if (c == 3) wr_data = 8'hFF;
    end
    vec++;
    if (rd_data !== 8'h3D) begin
      $display("FAIL ign_rd got %h want 3d", rd_data);
      errs++;
    end
    vec++;
    if (func !== 8'hC3) begin
      $display("FAIL ign_chain got %h want c3", func);
      errs++;
    end
`ifdef SCAN_PARITY_EN
    vec++;
    if (rd_parity !== 1'b1) begin
      $display("FAIL ign_par got %b want 1", rd_parity);
      errs++;
    end
`endif
    repeat (3) @(negedge cp);
    vec++;
    if ({busy, rd_valid, done} !== 3'b010) begin
      $display("FAIL ign_hold got %b want 010", {busy, rd_valid, done});
      errs++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
Sequences a serial chain of async-clear flip-flops through capture, shift and update phases, so a host can load and read back register state without a parallel path. Sits between the test/config host and a chain of CHAIN_LEN cells.
- One start request runs one full capture–shift–update cycle.
- The pattern to load is taken as parallel data; the captured contents are returned as parallel data.

Parameters:
CHAIN_LEN, 16, number of cells in the chain (legal range 2..1024)
CNT_W, $clog2(CHAIN_LEN+1), shift-counter width (derived; do not override)

Ports:
cp  input  1  clock, rising edge
cd  input  1  asynchronous active-low reset (clear)
start  input  1  request one scan operation; sampled only in IDLE
abort  input  1  cancel an operation; honoured only in SHIFT
wr_data  input  CHAIN_LEN  pattern to load into the chain; bit 0 is shifted first
chain_so  input  1  serial output from the chain tail
chain_si  output  1  serial input to the chain head
chain_ce  output  1  capture enable, one-cycle pulse
chain_se  output  1  shift enable
chain_ue  output  1  update enable, one-cycle pulse
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
aborted  output  1  one-cycle abort pulse
rd_valid  output  1  rd_data holds a completed capture
rd_data  output  CHAIN_LEN  captured data; first bit received at bit 0

Behaviour:
- Reset: cd is asynchronous and active-low. While cd=0:
  - state = IDLE; shift register, counter and all outputs = 0.
  - Clear takes effect immediately, including mid-SHIFT: chain_se drops without waiting for a clock edge.
- Machine is Moore. States: IDLE, CAPT, SHIFT, UPD.
- IDLE:
  - start=1 at an edge loads wr_data into the CHAIN_LEN-bit shift register sr, clears the counter, clears rd_valid, goes to CAPT.
  - start=0 stays in IDLE.
- CAPT (1 cycle): chain_ce=1, busy=1, then SHIFT.
- SHIFT (exactly CHAIN_LEN cycles):
  - chain_se=1, busy=1, chain_si=sr[0].
  - Each edge: sr <= {chain_so, sr[CHAIN_LEN-1:1]}; counter increments.
  - When counter reaches CHAIN_LEN-1 at an edge, go to UPD.
- UPD (1 cycle): chain_ue=1, busy=1, then IDLE with done=1 and rd_valid=1 for the next cycle.
- Timing: start sampled at edge 0 → CAPT in cycle 1 → SHIFT in cycles 2..CHAIN_LEN+1 → UPD in cycle CHAIN_LEN+2 → done in cycle CHAIN_LEN+3.
  - Total latency from start to done: CHAIN_LEN+3 cycles.
- chain_si=0 in every state except SHIFT.
- rd_data = sr at all times. It is meaningful only while rd_valid=1.
  - rd_valid stays high until the next accepted start or a reset.
- start while busy: ignored, not queued.
- start in the same cycle as done (IDLE): accepted; back-to-back operations are allowed.
- abort:
  - In SHIFT: next state IDLE, aborted=1 for one cycle; no UPD, no done; rd_valid stays 0.
  - In IDLE, CAPT or UPD: ignored.
  - abort and start together in IDLE: start wins.
- ce, se and ue are mutually exclusive in every cycle.

Optional Feature:
SCAN_PARITY_EN
- Defined:
  - Adds output rd_parity (1 bit) = XOR of all rd_data bits, registered alongside rd_valid.
  - rd_parity is 0 while rd_valid=0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package scan_pkg holds:
  - state enum scan_state_t {IDLE=2'd0, CAPT=2'd1, SHIFT=2'd2, UPD=2'd3};
  - localparam MIN_CHAIN_LEN=2.
- One natural sub-module: scan_shift_reg.
  - Parallel-load, right-shifting register with serial input.
  - Async active-low clear.
  - Instantiated once for sr.
- FSM and counter stay in the top module.

Test Plan:
All cases use CHAIN_LEN=8 with an 8-cell loopback chain model (cells shift on chain_se; on chain_ce they capture the value 8'h3C).
1. Reset: hold cd=0 for 3 cycles → all outputs 0; release, idle 5 cycles → busy=0, done=0, chain_se=0.
2. Basic op: start=1, wr_data=8'hA5 → chain_ce in cycle 1, chain_se in cycles 2..9, chain_ue in cycle 10, done in cycle 11; rd_data=8'h3C, rd_valid=1; chain model now holds 8'hA5.
3. Back-to-back: hold start=1 in the done cycle with wr_data=8'h0F → second op starts at once; rd_data=8'hA5 (the previously loaded pattern, since the model recaptures its contents); no idle gap.
4. Abort: start, then abort=1 in the 4th SHIFT cycle → aborted pulse next cycle, no chain_ue, no done, rd_valid=0; a following start completes normally.
5. Async reset mid-SHIFT: drop cd between edges in the 5th SHIFT cycle → chain_se and busy go to 0 before the next edge; a following start completes normally.
6. Ignored requests: start pulses during busy, abort during CAPT and UPD → no effect on timing or data. With SCAN_PARITY_EN, rd_parity=0 for 8'h3C and 1 for 8'h3D.
